// File: rtl/demux8_buffered.sv
// demux8_buffered: buffered 1-to-8 demultiplexer with a 2-entry in-order FIFO.
// Ports:
//   IN_CLK, IN_RST_N       clock, synchronous active-low reset
//   IN_VALID / OUT_READY   upstream handshake; OUT_READY is registered
//   IN_ADDR, IN_DATA       destination channel (0..7) and payload of the item
//   OUT_VALID              one-hot, bit k = channel k+1 holds the head item
//   IN_READY               bit k = channel k+1 accepts its item
//   OUT_DATA1..OUT_DATA8   per-channel payload, zero when the channel is idle
//   OUT_COUNT              FIFO occupancy 0..2
module demux8_buffered #(
  parameter int unsigned SIZE = 1
) (
  input  logic            IN_CLK,
  input  logic            IN_RST_N,
  input  logic            IN_VALID,
  output logic            OUT_READY,
  input  logic [2:0]      IN_ADDR,
  input  logic [SIZE-1:0] IN_DATA,
  output logic [7:0]      OUT_VALID,
  input  logic [7:0]      IN_READY,
  output logic [SIZE-1:0] OUT_DATA1,
  output logic [SIZE-1:0] OUT_DATA2,
  output logic [SIZE-1:0] OUT_DATA3,
  output logic [SIZE-1:0] OUT_DATA4,
  output logic [SIZE-1:0] OUT_DATA5,
  output logic [SIZE-1:0] OUT_DATA6,
  output logic [SIZE-1:0] OUT_DATA7,
  output logic [SIZE-1:0] OUT_DATA8,
  output logic [1:0]      OUT_COUNT
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned NCH   = 8;

  typedef struct packed {
    logic [2:0]      addr;
    logic [SIZE-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_n [DEPTH];
  entry_t          head_n;
  logic            wr_ptr_q, wr_ptr_n;
  logic            rd_ptr_q, rd_ptr_n;
  logic [1:0]      count_q, count_n;
  logic            ready_n;
  logic [7:0]      valid_n;
  logic [SIZE-1:0] data_q [NCH];
  logic [SIZE-1:0] data_n [NCH];
  logic            push_c, pop_c;

  // Next-state: handshakes, pointers, occupancy, and the head that will be
  // presented after this edge (outputs are registered from next-state values).
  always_comb begin
    push_c   = IN_VALID & OUT_READY;
    pop_c    = |(OUT_VALID & IN_READY);
    mem_n    = mem_q;
    if (push_c) begin
      mem_n[wr_ptr_q] = '{addr: IN_ADDR, data: IN_DATA};
    end
    wr_ptr_n = wr_ptr_q ^ push_c;
    rd_ptr_n = rd_ptr_q ^ pop_c;
    count_n  = 2'(count_q + 2'(push_c) - 2'(pop_c));
    ready_n  = (count_n < 2'd2);
    head_n   = mem_n[rd_ptr_n];
    valid_n  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      data_n[k] = '0;
    end
    if (count_n != 2'd0) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (head_n.addr == 3'(k)) begin
          valid_n[k] = 1'b1;
          data_n[k]  = head_n.data;
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge IN_CLK) begin
    if (!IN_RST_N) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      OUT_READY <= 1'b0;
      OUT_VALID <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
      count_q   <= count_n;
      OUT_READY <= ready_n;
      OUT_VALID <= valid_n;
      for (int unsigned k = 0; k < NCH; k++) begin
        data_q[k] <= data_n[k];
      end
    end
  end

  // Storage needs no reset; entries are only read while counted as valid.
  always_ff @(posedge IN_CLK) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_n[i];
    end
  end

  assign OUT_DATA1 = data_q[0];
  assign OUT_DATA2 = data_q[1];
  assign OUT_DATA3 = data_q[2];
  assign OUT_DATA4 = data_q[3];
  assign OUT_DATA5 = data_q[4];
  assign OUT_DATA6 = data_q[5];
  assign OUT_DATA7 = data_q[6];
  assign OUT_DATA8 = data_q[7];
  assign OUT_COUNT = count_q;

endmodule

// File: tb/tb_demux8_buffered.sv
// Testbench for demux8_buffered (SIZE=8): directed scenarios plus randomized
// traffic checked every cycle against a queue-based reference model.
module tb_demux8_buffered;

  localparam int unsigned SIZE = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic [2:0]      in_addr;
  logic [SIZE-1:0] in_data;
  logic [7:0]      out_valid;
  logic [7:0]      in_ready;
  logic [SIZE-1:0] od1, od2, od3, od4, od5, od6, od7, od8;
  logic [1:0]      out_count;
  logic [SIZE-1:0] od [8];

  int tests;
  int fails;
  bit chk_en;

  demux8_buffered #(.SIZE(SIZE)) dut (
    .IN_CLK   (clk),
    .IN_RST_N (rst_n),
    .IN_VALID (in_valid),
    .OUT_READY(out_ready),
    .IN_ADDR  (in_addr),
    .IN_DATA  (in_data),
    .OUT_VALID(out_valid),
    .IN_READY (in_ready),
    .OUT_DATA1(od1),
    .OUT_DATA2(od2),
    .OUT_DATA3(od3),
    .OUT_DATA4(od4),
    .OUT_DATA5(od5),
    .OUT_DATA6(od6),
    .OUT_DATA7(od7),
    .OUT_DATA8(od8),
    .OUT_COUNT(out_count)
  );

  assign od[0] = od1;
  assign od[1] = od2;
  assign od[2] = od3;
  assign od[3] = od4;
  assign od[4] = od5;
  assign od[5] = od6;
  assign od[6] = od7;
  assign od[7] = od8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an in-order queue of accepted items plus the ready flag.
  typedef struct {
    logic [2:0]      addr;
    logic [SIZE-1:0] data;
  } item_t;

  item_t mq[$];
  bit    m_ready = 1'b0;

  always @(posedge clk) begin
    bit m_push;
    bit m_pop;
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0;
    end else begin
      m_push = in_valid && m_ready;
      m_pop  = (mq.size() > 0) && in_ready[mq[0].addr];
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back('{addr: in_addr, data: in_data});
      m_ready = (mq.size() < 2);
    end
  end

  // Every cycle, compare DUT outputs with what the queue says should be shown.
  always @(negedge clk) begin
    logic [7:0]      e_valid;
    logic [SIZE-1:0] e_data [8];
    bit              data_ok;
    if (chk_en) begin
      e_valid = '0;
      for (int k = 0; k < 8; k++) e_data[k] = '0;
      if (mq.size() > 0) begin
        e_valid[mq[0].addr] = 1'b1;
        e_data[mq[0].addr]  = mq[0].data;
      end
      tests++;
      if (out_ready !== m_ready) begin
        fails++;
        $display("FAIL model_ready t=%0t got %0b exp %0b", $time, out_ready, m_ready);
      end
      tests++;
      if (out_valid !== e_valid) begin
        fails++;
        $display("FAIL model_valid t=%0t got %02h exp %02h", $time, out_valid, e_valid);
      end
      tests++;
      if (out_count !== 2'(mq.size())) begin
        fails++;
        $display("FAIL model_count t=%0t got %0d exp %0d", $time, out_count, mq.size());
      end
      data_ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (od[k] !== e_data[k]) data_ok = 1'b0;
      end
      tests++;
      if (!data_ok) begin
        fails++;
        $display("FAIL model_data t=%0t got %h %h %h %h %h %h %h %h exp %h %h %h %h %h %h %h %h",
                 $time, od[0], od[1], od[2], od[3], od[4], od[5], od[6], od[7],
                 e_data[0], e_data[1], e_data[2], e_data[3],
                 e_data[4], e_data[5], e_data[6], e_data[7]);
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_ready = '0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_addr  = 3'd3;
    in_data  = 8'h33;
    in_ready = '0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (out_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready got %0b exp 0", out_ready);
    end
    tests++;
    if (out_valid !== 8'h00) begin
      fails++; $display("FAIL reset_valid got %02h exp 00", out_valid);
    end
    tests++;
    if (out_count !== 2'd0) begin
      fails++; $display("FAIL reset_count got %0d exp 0", out_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (out_ready !== 1'b1) begin
      fails++; $display("FAIL release_ready got %0b exp 1", out_ready);
    end
    tests++;
    if (out_count !== 2'd0) begin
      fails++; $display("FAIL release_no_push got %0d exp 0", out_count);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_single();
    bit others_zero;
    in_valid = 1'b1;
    in_addr  = 3'd5;
    in_data  = 8'hA5;
    in_ready = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 8'h20) begin
      fails++; $display("FAIL single_valid got %02h exp 20", out_valid);
    end
    tests++;
    if (od6 !== 8'hA5) begin
      fails++; $display("FAIL single_data6 got %02h exp a5", od6);
    end
    others_zero = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k != 5 && od[k] !== 8'h00) others_zero = 1'b0;
    end
    tests++;
    if (!others_zero) begin
      fails++; $display("FAIL single_others got %h%h%h%h%h_%h%h exp zeros",
                        od1, od2, od3, od4, od5, od7, od8);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 8'h00 || out_count !== 2'd0) begin
      fails++; $display("FAIL single_drain got valid %02h count %0d exp 00 0", out_valid, out_count);
    end
    idle_inputs();
  endtask

  task automatic test_full();
    in_ready = 8'h00;
    in_valid = 1'b1;
    in_addr  = 3'd1;
    in_data  = 8'h11;
    @(negedge clk);
    in_addr  = 3'd2;
    in_data  = 8'h22;
    @(negedge clk);
    tests++;
    if (out_count !== 2'd2 || out_ready !== 1'b0) begin
      fails++; $display("FAIL full_state got count %0d ready %0b exp 2 0", out_count, out_ready);
    end
    in_addr = 3'd3;
    in_data = 8'h33;
    repeat (2) @(negedge clk);
    tests++;
    if (out_count !== 2'd2 || out_valid !== 8'h02 || od2 !== 8'h11) begin
      fails++; $display("FAIL full_third_rejected got count %0d valid %02h d2 %02h exp 2 02 11",
                        out_count, out_valid, od2);
    end
    in_valid = 1'b0;
    in_ready = 8'h02;
    @(negedge clk);
    in_ready = 8'h00;
    tests++;
    if (out_ready !== 1'b1 || out_count !== 2'd1) begin
      fails++; $display("FAIL full_pop got ready %0b count %0d exp 1 1", out_ready, out_count);
    end
    tests++;
    if (out_valid !== 8'h04 || od3 !== 8'h22) begin
      fails++; $display("FAIL full_next_head got valid %02h d3 %02h exp 04 22", out_valid, od3);
    end
    in_ready = 8'hFF;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_wrong_channel();
    in_valid = 1'b1;
    in_addr  = 3'd0;
    in_data  = 8'h5A;
    in_ready = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    in_ready = 8'hFE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 8'h01 || out_count !== 2'd1 || od1 !== 8'h5A) begin
        fails++; $display("FAIL wrong_ch cyc%0d got valid %02h count %0d d1 %02h exp 01 1 5a",
                          c, out_valid, out_count, od1);
      end
    end
    in_ready = 8'h01;
    @(negedge clk);
    tests++;
    if (out_count !== 2'd0) begin
      fails++; $display("FAIL wrong_ch_drain got %0d exp 0", out_count);
    end
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [7:0] rec [8][4];
    int         rcnt [8];
    bit         ok;
    for (int k = 0; k < 8; k++) rcnt[k] = 0;
    in_ready = 8'hFF;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16);
      in_addr  = 3'(i % 8);
      in_data  = 8'(i);
      @(negedge clk);
      tests++;
      if (out_ready !== 1'b1) begin
        fails++; $display("FAIL stream_ready cyc%0d got %0b exp 1", i, out_ready);
      end
      for (int k = 0; k < 8; k++) begin
        if (out_valid[k] && rcnt[k] < 4) begin
          rec[k][rcnt[k]] = od[k];
          rcnt[k]++;
        end
      end
    end
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (rcnt[k] != 2 || rec[k][0] !== 8'(k) || rec[k][1] !== 8'(k + 8)) ok = 1'b0;
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL stream_order got ch0 n=%0d ch7 n=%0d exp 2 each with i,i+8",
                        rcnt[0], rcnt[7]);
    end
    tests++;
    if (out_count !== 2'd0) begin
      fails++; $display("FAIL stream_final_count got %0d exp 0", out_count);
    end
    idle_inputs();
  endtask

  task automatic test_simul();
    in_valid = 1'b1;
    in_addr  = 3'd3;
    in_data  = 8'h33;
    in_ready = 8'h00;
    @(negedge clk);
    in_addr  = 3'd7;
    in_data  = 8'h77;
    in_ready = 8'h08;
    @(negedge clk);
    in_valid = 1'b0;
    in_ready = 8'h00;
    tests++;
    if (out_count !== 2'd1 || out_valid !== 8'h80 || od8 !== 8'h77) begin
      fails++; $display("FAIL simul got count %0d valid %02h d8 %02h exp 1 80 77",
                        out_count, out_valid, od8);
    end
    in_ready = 8'h80;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    in_ready = 8'h00;
    in_valid = 1'b1;
    in_addr  = 3'd4;
    in_data  = 8'h44;
    @(negedge clk);
    in_data  = 8'h45;
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_ready = 8'hFF;
    @(negedge clk);
    tests++;
    if (out_count !== 2'd0 || out_valid !== 8'h00 || out_ready !== 1'b0 || od5 !== 8'h00) begin
      fails++; $display("FAIL reset_mid got count %0d valid %02h ready %0b d5 %02h exp 0 00 0 00",
                        out_count, out_valid, out_ready, od5);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (out_ready !== 1'b1 || out_count !== 2'd0) begin
      fails++; $display("FAIL reset_mid_release got ready %0b count %0d exp 1 0", out_ready, out_count);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = 3'($urandom_range(0, 7));
      in_data  = 8'($urandom);
      in_ready = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle_inputs();
    in_ready = 8'hFF;
    repeat (4) @(negedge clk);
    tests++;
    if (out_count !== 2'd0) begin
      fails++; $display("FAIL random_drain got %0d exp 0", out_count);
    end
    idle_inputs();
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_full();
    test_wrong_channel();
    test_stream();
    test_simul();
    test_reset_mid();
    test_random();
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
